// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/step/breakpoint controller.
// The state encoding is visible on state_o, so the enum values are fixed.
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_HALT = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10,
      ST_BRK  = 2'b11
   } run_state_e;

   localparam int PC_W     = 32;
   localparam int ICOUNT_W = 32;

   function automatic logic is_halted(input run_state_e s);
      return (s == ST_HALT) || (s == ST_BRK);
   endfunction

endpackage

// File: rtl/step_debounce.sv
// Step-button debouncer: the level rises after DEB_CYCLES consecutive high
// samples and drops on any low sample; pulse_o marks each rising edge of it.
module step_debounce #(
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic pulse_o
);

   localparam int               CNT_W  = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEB_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lvl_q, lvl_d;
   logic             lvl_prev_q, lvl_prev_d;

   // Counter saturates at terminal count so a held button stays debounced.
   always_comb begin
      cnt_d      = '0;
      lvl_d      = 1'b0;
      lvl_prev_d = lvl_q;
      if (btn_i) begin
         cnt_d = (cnt_q == CNT_TC) ? cnt_q : cnt_q + CNT_W'(1);
         lvl_d = (cnt_d == CNT_TC);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         lvl_q      <= 1'b0;
         lvl_prev_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         lvl_q      <= lvl_d;
         lvl_prev_q <= lvl_prev_d;
      end
   end

   assign pulse_o = lvl_q & ~lvl_prev_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: free-run, divided slow-run, single-step and PC breakpoint,
// producing the CPU clock-enable and a retired-instruction counter.
//
// state | meaning
// ------+----------------------------------------------------------------
// HALT  | CPU frozen; waits for run switch or a debounced step press
// RUN   | free/slow run; enable on each tick unless the PC hits breakpoint
// STEP  | exactly one enabled cycle, breakpoints ignored, then HALT
// BRK   | stopped on breakpoint; step executes it, run switch off -> HALT
module cpu_run_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int DIV_W      = 25,
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run_i,
   input  logic                slow_i,
   input  logic                step_i,
   input  logic                bp_en_i,
   input  logic [PC_W-1:0]     bp_addr_i,
   input  logic [PC_W-1:0]     pc_i,
   output logic                cpu_en_o,
   output logic [1:0]          state_o,
   output logic                halted_o,
   output logic [ICOUNT_W-1:0] icount_o
);

   run_state_e          state_q, state_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [ICOUNT_W-1:0] icount_q, icount_d;
   logic                step_pulse;
   logic                bp_hit;
   logic                tick;
   logic                cpu_en;

   step_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_step_debounce (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (step_i),
      .pulse_o (step_pulse)
   );

   assign bp_hit = bp_en_i & (pc_i == bp_addr_i);
   assign tick   = ~slow_i | (&div_q);

   always_comb begin
      state_d = state_q;
      cpu_en  = 1'b0;
      unique case (state_q)
         ST_HALT: begin
            if (run_i)           state_d = ST_RUN;
            else if (step_pulse) state_d = ST_STEP;
         end
         ST_RUN: begin
            // The breakpoint instruction is held off, not executed, on a hit.
            cpu_en = run_i & tick & ~bp_hit;
            if (!run_i)      state_d = ST_HALT;
            else if (bp_hit) state_d = ST_BRK;
         end
         ST_STEP: begin
            cpu_en  = 1'b1;
            state_d = ST_HALT;
         end
         ST_BRK: begin
            if (!run_i)          state_d = ST_HALT;
            else if (step_pulse) state_d = ST_STEP;
         end
         default: state_d = ST_HALT;
      endcase
      // Reset aborts any enable so nothing commits in the reset cycle.
      if (rst) cpu_en = 1'b0;
   end

   always_comb begin
      div_d = '0;
      if (state_q == ST_RUN) begin
         div_d = slow_i ? div_q + DIV_W'(1) : div_q;
      end
   end

   assign icount_d = icount_q + ICOUNT_W'(cpu_en);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_HALT;
         div_q    <= '0;
         icount_q <= '0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         icount_q <= icount_d;
      end
   end

   assign cpu_en_o = cpu_en;
   assign state_o  = state_q;
   assign halted_o = is_halted(state_q);
   assign icount_o = icount_q;

endmodule
